// File: rtl/cordic_iter_unit.sv
// cordic_iter_unit: iterative CORDIC (trig, rotate, vectoring) with valid/ready handshake
module cordic_iter_unit #(
  parameter int N = 32,
  parameter int I = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          mode,
  input  logic signed [N-1:0] angle,
  input  logic signed [N-1:0] Xi,
  input  logic signed [N-1:0] Yi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] sin,
  output logic signed [N-1:0] cos,
  output logic signed [N-1:0] Xr,
  output logic signed [N-1:0] Yr,
  output logic signed [N-1:0] mag,
  output logic signed [N-1:0] phase
);
  localparam int FRAC = N - 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_ROT = 2'd1, S_SCALE = 2'd2, S_DONE = 2'd3;
  localparam logic [31:0] ATAN [0:27] = '{
    32'h0C90FDAA, 32'h076B19C1, 32'h03EB6EBF, 32'h01FD5BA9, 32'h00FFAADD, 32'h007FF556,
    32'h003FFEAA, 32'h001FFFD5, 32'h000FFFFA, 32'h0007FFFF, 32'h0003FFFF, 32'h0001FFFF,
    32'h0000FFFF, 32'h00007FFF, 32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
    32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F, 32'h0000003F, 32'h0000001F,
    32'h0000000F, 32'h00000008, 32'h00000004, 32'h00000002};
  localparam logic [31:0] HALF_PI32 = 32'h1921FB54;
  localparam logic [31:0] K32 = 32'h09B74EDA;
  localparam logic signed [N-1:0] HALF_PI = HALF_PI32[31 -: N];
  localparam logic signed [N-1:0] KN = K32[31 -: N];
  localparam logic signed [N-1:0] ONE = N'(1) <<< FRAC;
  function automatic logic signed [N-1:0] scl(input logic signed [N-1:0] v);
    logic signed [2*N-1:0] p;
    p = v * KN;
    return N'(p >>> FRAC);
  endfunction
  logic [1:0] st_q, st_d, md_q, md_d;
  logic [4:0] k_q, k_d;
  logic sc_q, sc_d;
  logic signed [N-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [N-1:0] sin_q, sin_d, cos_q, cos_d, xr_q, xr_d, yr_q, yr_d, mag_q, mag_d, ph_q, ph_d;
  logic trig, vec, dpos;
  logic signed [N-1:0] xs, ys, xsh, ysh, at;
  always_comb begin
    st_d = st_q;
    md_d = md_q;
    k_d = k_q;
    sc_d = sc_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    sin_d = sin_q;
    cos_d = cos_q;
    xr_d = xr_q;
    yr_d = yr_q;
    mag_d = mag_q;
    ph_d = ph_q;
    trig = mode[1] == mode[0];
    vec = mode == 2'b10;
    xs = trig ? ONE : Xi;
    ys = trig ? '0 : Yi;
    xsh = x_q >>> k_q;
    ysh = y_q >>> k_q;
    at = ATAN[k_q][31 -: N];
    dpos = md_q == 2'b10 ? y_q < 0 : z_q >= 0;
    if (st_q == S_IDLE && in_valid) begin
      st_d = S_ROT;
      md_d = trig ? 2'b00 : mode;
      k_d = '0;
      if (vec) begin
        x_d = xs < 0 ? (ys >= 0 ? ys : -ys) : xs;
        y_d = xs < 0 ? (ys >= 0 ? -xs : xs) : ys;
        z_d = xs < 0 ? (ys >= 0 ? HALF_PI : -HALF_PI) : '0;
      end else begin
        x_d = angle > HALF_PI ? -ys : angle < -HALF_PI ? ys : xs;
        y_d = angle > HALF_PI ? xs : angle < -HALF_PI ? -xs : ys;
        z_d = angle > HALF_PI ? angle - HALF_PI : angle < -HALF_PI ? angle + HALF_PI : angle;
      end
    end else if (st_q == S_ROT) begin
      x_d = dpos ? x_q - ysh : x_q + ysh;
      y_d = dpos ? y_q + xsh : y_q - xsh;
      z_d = dpos ? z_q - at : z_q + at;
      k_d = k_q == 5'(I - 1) ? '0 : k_q + 5'd1;
      st_d = k_q == 5'(I - 1) ? S_SCALE : S_ROT;
      sc_d = 1'b0;
    end else if (st_q == S_SCALE && !sc_q) begin
      // first SCALE cycle registers the gain-corrected vector, second publishes results
      x_d = scl(x_q);
      y_d = scl(y_q);
      sc_d = 1'b1;
    end else if (st_q == S_SCALE) begin
      st_d = S_DONE;
      sin_d = md_q == 2'b00 ? y_q : '0;
      cos_d = md_q == 2'b00 ? x_q : '0;
      xr_d = md_q == 2'b01 ? x_q : '0;
      yr_d = md_q == 2'b01 ? y_q : '0;
      mag_d = md_q == 2'b10 ? x_q : '0;
      ph_d = md_q == 2'b10 ? z_q : '0;
    end else if (st_q == S_DONE && out_ready) begin
      st_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_IDLE;
      md_q <= '0;
      k_q <= '0;
      sc_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      sin_q <= '0;
      cos_q <= '0;
      xr_q <= '0;
      yr_q <= '0;
      mag_q <= '0;
      ph_q <= '0;
    end else begin
      st_q <= st_d;
      md_q <= md_d;
      k_q <= k_d;
      sc_q <= sc_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      sin_q <= sin_d;
      cos_q <= cos_d;
      xr_q <= xr_d;
      yr_q <= yr_d;
      mag_q <= mag_d;
      ph_q <= ph_d;
    end
  end
  assign in_ready = st_q == S_IDLE;
  assign out_valid = st_q == S_DONE;
  assign sin = sin_q;
  assign cos = cos_q;
  assign Xr = xr_q;
  assign Yr = yr_q;
  assign mag = mag_q;
  assign phase = ph_q;
endmodule

// File: tb/tb_cordic_iter_unit.sv
// tb_cordic_iter_unit: directed self-checking bench with a real-arithmetic reference model
module tb_cordic_iter_unit;
  localparam longint TOL = 2048;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [1:0] mode = 0;
  logic signed [31:0] angle = 0, xi = 0, yi = 0;
  logic in_ready, out_valid;
  logic signed [31:0] sin, cos, xr, yr, mag, phase;
  int cnt = 0, errs = 0;
  longint e_sin, e_cos, e_xr, e_yr, e_mag, e_ph;
  logic pv = 0;
  logic [191:0] prev;
  cordic_iter_unit #(.N(32), .I(20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .angle(angle), .Xi(xi), .Yi(yi), .out_valid(out_valid), .out_ready(out_ready),
    .sin(sin), .cos(cos), .Xr(xr), .Yr(yr), .mag(mag), .phase(phase));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
    cnt++;
    if (act - exp > tol || exp - act > tol) begin
      errs++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask
  function automatic real r(input logic signed [31:0] v);
    return real'(v) / 268435456.0;
  endfunction
  function automatic longint fx(input real v);
    return longint'(v * 268435456.0);
  endfunction
  task automatic model(input logic [1:0] m, input logic signed [31:0] a, input logic signed [31:0] x, input logic signed [31:0] y);
    real ar;
    ar = r(a);
    {e_sin, e_cos, e_xr, e_yr, e_mag, e_ph} = '0;
    if (m == 2'b01) begin
      e_xr = fx(r(x) * $cos(ar) - r(y) * $sin(ar));
      e_yr = fx(r(x) * $sin(ar) + r(y) * $cos(ar));
    end else if (m == 2'b10) begin
      e_mag = fx($sqrt(r(x) * r(x) + r(y) * r(y)));
      e_ph = fx($atan2(r(y), r(x)));
    end else begin
      e_sin = fx($sin(ar));
      e_cos = fx($cos(ar));
    end
  endtask
  always @(negedge clk) begin
    if (rst) pv <= 0;
    else begin
      if (out_valid) begin
        chk("sin", sin, e_sin, e_sin == 0 && e_cos == 0 ? 0 : TOL);
        chk("cos", cos, e_cos, e_sin == 0 && e_cos == 0 ? 0 : TOL);
        chk("Xr", xr, e_xr, e_xr == 0 && e_yr == 0 ? 0 : TOL);
        chk("Yr", yr, e_yr, e_xr == 0 && e_yr == 0 ? 0 : TOL);
        chk("mag", mag, e_mag, e_mag == 0 ? 0 : TOL);
        chk("phase", phase, e_ph, e_mag == 0 ? 0 : TOL);
        if (pv) chk("stable", longint'(prev !== {sin, cos, xr, yr, mag, phase}), 0, 0);
      end
      pv <= out_valid;
      prev <= {sin, cos, xr, yr, mag, phase};
    end
  end
  task automatic run_op(input logic [1:0] m, input logic signed [31:0] a, input logic signed [31:0] x, input logic signed [31:0] y, input int hold);
    int lat;
    model(m, a, x, y);
    mode = m; angle = a; xi = x; yi = y; in_valid = 1;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 100) begin
      in_valid = lat < 5;
      mode = 2'b10; xi = 32'h0123_4567; yi = 32'h7654_3210; angle = 32'h1000_0000;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 0;
    chk("latency", lat, 22, 0);
    repeat (hold) @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    chk("out_valid_after", out_valid, 0, 0);
    chk("in_ready_after", in_ready, 1, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", in_ready, 1, 0);
    chk("rst_out_valid", out_valid, 0, 0);
    chk("rst_results", longint'({sin, cos, xr, yr, mag, phase} != '0), 0, 0);
    run_op(2'b00, 32'h10C15238, 0, 0, 5);
    chk("lit_sin_pi3", sin, 32'h0DDB3D74, TOL);
    chk("lit_cos_pi3", cos, 32'h08000000, TOL);
    run_op(2'b00, 32'h2182A471, 0, 0, 0);
    chk("lit_sin_2pi3", sin, 32'h0DDB3D74, TOL);
    chk("lit_cos_2pi3", cos, 64'shFFFFFFFFF8000000, TOL);
    run_op(2'b01, 32'h0C90FDAA, 32'h0B504F33, 32'h0B504F33, 1);
    chk("lit_xr", xr, 0, TOL);
    chk("lit_yr", yr, 32'h10000000, TOL);
    chk("lit_sin_cleared", sin, 0, 0);
    run_op(2'b10, 0, 32'hF0000000, 0, 2);
    chk("lit_mag", mag, 32'h10000000, TOL);
    chk("lit_phase", phase, 32'h3243F6A9, TOL);
    run_op(2'b00, 32'hDE7D5B8F, 0, 0, 0);
    run_op(2'b00, 0, 0, 0, 0);
    run_op(2'b11, 32'h10C15238, 0, 0, 0);
    run_op(2'b00, 32'h3243F6A9, 0, 0, 0);
    run_op(2'b01, 32'hE6DE04AC, 32'h18000000, 32'hF8000000, 0);
    run_op(2'b01, 32'h2D97C7F3, 32'h08000000, 32'h04000000, 0);
    run_op(2'b10, 0, 32'h10000000, 32'h10000000, 0);
    run_op(2'b10, 0, 32'hF0000000, 32'hF0000000, 0);
    run_op(2'b10, 0, 32'hE8000000, 32'h08000000, 0);
    model(2'b00, 32'h10C15238, 0, 0);
    mode = 2'b00; angle = 32'h10C15238; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (10) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("mid_rst_in_ready", in_ready, 1, 0);
    chk("mid_rst_out_valid", out_valid, 0, 0);
    chk("mid_rst_results", longint'({sin, cos, xr, yr, mag, phase} != '0), 0, 0);
    begin
      int bad = 0;
      repeat (30) begin
        @(posedge clk); #1;
        if (out_valid) bad++;
      end
      chk("no_emit_after_rst", bad, 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, cnt);
    $finish;
  end
endmodule
